// File: rtl/uart_scheduler.sv
// Round-robin scheduler that grants one of CHANNEL_AMOUNT UART channels access to a shared link.
// A synchronized host override (FORCE) can pin the enable to a chosen channel.
module uart_scheduler #(
    parameter int CHANNEL_AMOUNT = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNEL_AMOUNT-1:0] req,
    input  logic                      done,
    input  logic                      force_en,
    input  logic [15:0]               force_sel,
    output logic [CHANNEL_AMOUNT-1:0] uart_en,
    output logic [3:0]                grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2,
        FORCE = 2'd3
    } state_e;

    localparam logic [15:0] LOW_MASK  = 16'((32'd1 << CHANNEL_AMOUNT) - 32'd1);
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  LAST_INIT = 4'(CHANNEL_AMOUNT - 1);

    state_e                    state_q, state_d;
    logic [CHANNEL_AMOUNT-1:0] uart_en_q, uart_en_d;
    logic [3:0]                grant_id_q, grant_id_d;
    logic                      busy_q, busy_d;
    logic                      tout_q, tout_d;
    logic [15:0]               cnt_q, cnt_d;
    logic [3:0]                last_id_q, last_id_d;
    logic                      fen_meta_q, fen_s_q;
    logic [15:0]               fsel_meta_q, fsel_s_q;

    logic                      rr_found;
    logic [3:0]                rr_id;
    logic                      fsel_valid;
    logic [CHANNEL_AMOUNT-1:0] force_vec;

    function automatic logic [3:0] enc(input logic [CHANNEL_AMOUNT-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int j = 0; j < CHANNEL_AMOUNT; j++) begin
            if (v[j]) r = 4'(j);
        end
        return r;
    endfunction

    // Round-robin: lowest requester above last_id wins; otherwise wrap to the lowest overall.
    always_comb begin
        logic       hi_found, lo_found;
        logic [3:0] hi_id, lo_id;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = 4'd0;
        lo_id    = 4'd0;
        for (int j = CHANNEL_AMOUNT - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (4'(j) > last_id_q) begin
                    hi_found = 1'b1;
                    hi_id    = 4'(j);
                end else begin
                    lo_found = 1'b1;
                    lo_id    = 4'(j);
                end
            end
        end
        rr_found = hi_found | lo_found;
        rr_id    = hi_found ? hi_id : lo_id;
    end

    // Override word is honoured only when it selects exactly one existing channel.
    always_comb begin
        fsel_valid = (fsel_s_q != 16'd0) &&
                     ((fsel_s_q & (fsel_s_q - 16'd1)) == 16'd0) &&
                     ((fsel_s_q & ~LOW_MASK) == 16'd0);
        force_vec  = fsel_valid ? fsel_s_q[CHANNEL_AMOUNT-1:0] : '0;
    end

    always_comb begin
        state_d   = state_q;
        uart_en_d = uart_en_q;
        cnt_d     = cnt_q;
        last_id_d = last_id_q;
        tout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                uart_en_d = '0;
                if (fen_s_q) begin
                    state_d   = FORCE;
                    uart_en_d = force_vec;
                end else if (rr_found) begin
                    state_d   = GRANT;
                    uart_en_d = {{(CHANNEL_AMOUNT-1){1'b0}}, 1'b1} << rr_id;
                    last_id_d = rr_id;
                    cnt_d     = 16'd0;
                end
            end
            GRANT: begin
                // uart_en_q is one-hot here, so the AND tests req of the granted channel.
                if (fen_s_q || done || ((req & uart_en_q) == '0)) begin
                    state_d   = GAP;
                    uart_en_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = GAP;
                    uart_en_d = '0;
                    tout_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                state_d   = IDLE;
                uart_en_d = '0;
            end
            FORCE: begin
                if (!fen_s_q) begin
                    state_d   = GAP;
                    uart_en_d = '0;
                end else begin
                    uart_en_d = force_vec;
                end
            end
            default: begin
                state_d   = IDLE;
                uart_en_d = '0;
            end
        endcase
        busy_d     = (state_d == GRANT) || (state_d == FORCE);
        grant_id_d = enc(uart_en_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            uart_en_q   <= '0;
            grant_id_q  <= 4'd0;
            busy_q      <= 1'b0;
            tout_q      <= 1'b0;
            cnt_q       <= 16'd0;
            last_id_q   <= LAST_INIT;
            fen_meta_q  <= 1'b0;
            fen_s_q     <= 1'b0;
            fsel_meta_q <= 16'd0;
            fsel_s_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            uart_en_q   <= uart_en_d;
            grant_id_q  <= grant_id_d;
            busy_q      <= busy_d;
            tout_q      <= tout_d;
            cnt_q       <= cnt_d;
            last_id_q   <= last_id_d;
            fen_meta_q  <= force_en;
            fen_s_q     <= fen_meta_q;
            fsel_meta_q <= force_sel;
            fsel_s_q    <= fsel_meta_q;
        end
    end

    assign uart_en     = uart_en_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign timeout_err = tout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_scheduler.sv
// Directed bench for uart_scheduler: arbitration order, gap, timeout, override and async reset.
module tb_uart_scheduler;

    localparam int N = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FORCE = 2'd3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] req;
    logic         done;
    logic         force_en;
    logic [15:0]  force_sel;
    logic [N-1:0] uart_en;
    logic [3:0]   grant_id;
    logic         busy;
    logic         timeout_err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    uart_scheduler #(
        .CHANNEL_AMOUNT(N),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .done(done),
        .force_en(force_en),
        .force_sel(force_sel),
        .uart_en(uart_en),
        .grant_id(grant_id),
        .busy(busy),
        .timeout_err(timeout_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_ids[3];
        int hi_cnt;
        int tout_seen;
        a_ids = '{0, 2, 0};

        reset_n   = 1'b0;
        req       = '0;
        done      = 1'b0;
        force_en  = 1'b0;
        force_sel = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", uart_en, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tout", timeout_err, 0);
        chk("rst_state", dbg_state, S_IDLE);
        reset_n = 1'b1;
        step();
        chk("idle_hold", dbg_state, S_IDLE);

        // Round robin between channels 0 and 2 with done pulses.
        req = 8'h05;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("rr_en", uart_en, 8'h01 << a_ids[k]);
            chk("rr_gid", grant_id, a_ids[k]);
            chk("rr_busy", busy, 1);
            step();
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rr_gap_en", uart_en, 0);
            chk("rr_gap_state", dbg_state, S_GAP);
            step();
            chk("rr_idle_state", dbg_state, S_IDLE);
            step();
        end
        req = '0;
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("done_ignored_state", dbg_state, S_IDLE);
        chk("done_ignored_en", uart_en, 0);

        // Timeout on channel 7.
        req = 8'h80;
        step();
        hi_cnt    = 0;
        tout_seen = 0;
        while (uart_en == 8'h80 && hi_cnt < 40) begin
            hi_cnt++;
            if (timeout_err) tout_seen++;
            step();
        end
        chk("to_len", hi_cnt, 16);
        chk("to_early", tout_seen, 0);
        chk("to_pulse", timeout_err, 1);
        chk("to_gap", dbg_state, S_GAP);
        step();
        chk("to_pulse_end", timeout_err, 0);
        chk("to_gap_en", uart_en, 0);
        step();
        chk("to_regrant", uart_en, 8'h80);
        req = '0;
        step();
        step();

        // Override arrives during a grant to channel 1.
        req = 8'h02;
        step();
        chk("fc_grant", uart_en, 8'h02);
        chk("fc_gid", grant_id, 1);
        force_en  = 1'b1;
        force_sel = 16'h0020;
        step();
        chk("fc_sync1", uart_en, 8'h02);
        step();
        chk("fc_sync2", uart_en, 8'h02);
        step();
        chk("fc_gap_en", uart_en, 0);
        chk("fc_gap_state", dbg_state, S_GAP);
        step();
        chk("fc_idle", dbg_state, S_IDLE);
        step();
        chk("fc_en", uart_en, 8'h20);
        chk("fc_gid5", grant_id, 5);
        chk("fc_busy", busy, 1);
        chk("fc_state", dbg_state, S_FORCE);

        // Illegal override words give no enable.
        force_sel = 16'h0003;
        step();
        step();
        chk("fv_lat", uart_en, 8'h20);
        step();
        chk("fv_two_bits", uart_en, 0);
        chk("fv_two_gid", grant_id, 0);
        chk("fv_two_busy", busy, 1);
        force_sel = 16'h0100;
        step();
        step();
        step();
        chk("fv_range", uart_en, 0);
        force_sel = 16'h0004;
        step();
        step();
        step();
        chk("fv_ok", uart_en, 8'h04);
        chk("fv_ok_gid", grant_id, 2);

        // Leave override; last_id must still be 1 so channel 2 wins over 1.
        req      = 8'h06;
        force_en = 1'b0;
        step();
        step();
        chk("fx_hold", uart_en, 8'h04);
        step();
        chk("fx_gap", uart_en, 0);
        chk("fx_gap_busy", busy, 0);
        step();
        step();
        chk("fx_next", uart_en, 8'h04);
        chk("fx_next_gid", grant_id, 2);

        // Request dropped mid-grant.
        req = 8'h48;
        step();
        step();
        step();
        chk("rd_grant3", uart_en, 8'h08);
        step();
        chk("rd_hold3", uart_en, 8'h08);
        req = 8'h40;
        step();
        chk("rd_gap", uart_en, 0);
        chk("rd_gap_state", dbg_state, S_GAP);
        step();
        step();
        chk("rd_grant6", uart_en, 8'h40);
        chk("rd_gid6", grant_id, 6);

        // Asynchronous reset mid-grant.
        req = '0;
        step();
        step();
        req = 8'h10;
        step();
        chk("ar_grant", uart_en, 8'h10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_en", uart_en, 0);
        chk("ar_busy", busy, 0);
        chk("ar_gid", grant_id, 0);
        chk("ar_state", dbg_state, S_IDLE);
        req = 8'hFF;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("ar_first", uart_en, 8'h01);
        chk("ar_first_gid", grant_id, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_scheduler.md
UART_SCHEDULER -- requirements
Module: uart_scheduler

Interface
REQ-001 SHALL have parameter CHANNEL_AMOUNT, default 8, number of UART channels sharing the link (legal range 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum grant length in clk cycles (legal range 2..65535).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req  input  CHANNEL_AMOUNT  per-channel access request, synchronous to clk, level.
REQ-007 done  input  1  single-cycle pulse: granted channel finished its transfer.
REQ-008 force_en  input  1  host override enable, asynchronous to clk.
REQ-009 force_sel  input  16  host override channel word, asynchronous to clk.
REQ-010 uart_en  output  CHANNEL_AMOUNT  registered channel enable; zero or one-hot.
REQ-011 grant_id  output  4  binary index of the active uart_en bit; 0 when uart_en is zero.
REQ-012 busy  output  1  high in GRANT or FORCE.
REQ-013 timeout_err  output  1  single-cycle pulse on grant timeout.

Function
REQ-014 SHALL pass force_en and force_sel through a two-flop synchronizer; all use is of the second stage (fen_s, fsel_s).
REQ-015 SHALL implement FSM states IDLE, GRANT, GAP, FORCE; all outputs registered.
REQ-016 IDLE: fen_s=1 -> FORCE (priority); else any req bit set -> GRANT; else stay.
REQ-017 Arbitration SHALL be round-robin: the winner is the first set req bit searching upward from last_id+1 and wrapping modulo CHANNEL_AMOUNT; last_id resets to CHANNEL_AMOUNT-1, so channel 0 wins first.
REQ-018 uart_en SHALL assert on the first clock edge after the IDLE cycle in which req is sampled (1-cycle latency); last_id updates to the winner on that same edge.
REQ-019 GRANT: a 16-bit counter SHALL clear on entry and increment each cycle.
REQ-020 GRANT exit priority, highest first: fen_s=1 -> GAP; done=1 -> GAP; req[grant_id]=0 -> GAP; counter=TIMEOUT_CYCLES-1 -> GAP with timeout_err pulsed on the same edge.
REQ-021 GAP SHALL last exactly one cycle with uart_en=0, then -> IDLE; this guarantees at least one idle cycle between grants.
REQ-022 FORCE: uart_en SHALL equal fsel_s[CHANNEL_AMOUNT-1:0] when fsel_s has exactly one bit set and that bit index is < CHANNEL_AMOUNT; otherwise uart_en=0; re-evaluated every cycle.
REQ-023 FORCE: fen_s=0 -> GAP; last_id is not modified by FORCE.
REQ-024 done outside GRANT SHALL be ignored; a req bit dropped and re-raised re-enters arbitration normally.
REQ-025 grant_id SHALL encode uart_en every cycle, including in FORCE.

Reset
REQ-026 reset_n low SHALL asynchronously force: state=IDLE, uart_en=0, grant_id=0, busy=0, timeout_err=0, counter=0, last_id=CHANNEL_AMOUNT-1, synchronizer flops=0.
REQ-027 reset_n asserted mid-GRANT or mid-FORCE SHALL drop uart_en in the same cycle without waiting for clk; after release, the first grant goes to the lowest requesting channel.

Verification
REQ-028 req=8'b0000_0101 held, done pulsed 3 cycles after each grant -> uart_en 0x01, gap, 0x04, gap, 0x01; grant_id 0,2,0.
REQ-029 req=8'h80 held, no done, TIMEOUT_CYCLES=16 -> uart_en=0x80 for exactly 16 cycles, timeout_err single pulse, one GAP cycle, regrant 0x80.
REQ-030 force_en=1, force_sel=16'h0020 during a grant to channel 1 -> 2 cycles sync, GAP, FORCE with uart_en=0x20, grant_id=5, busy=1.
REQ-031 FORCE with force_sel=16'h0003, then 16'h0100 (CHANNEL_AMOUNT=8) -> uart_en=0 for both values; 16'h0004 -> 0x04.
REQ-032 reset_n pulled low while uart_en=0x10 -> uart_en=0 immediately; release with req=8'hFF -> first grant 0x01.
REQ-033 req[3] dropped mid-grant with req[6] set -> GAP next edge, then uart_en=0x40.
